multi_timer_io_device: RTL and testbench

Parametrised timer peripheral on the I/O controller bus; the next generation of the simple I/O device's free-running counters. Provides up to three independent down-counting timers driven by a shared programmable prescaler. Each timer supports one-shot or auto-reload mode, a sticky write-1-to-clear expiry flag and a maskable interrupt. Occupies one 16-register device slot and reads/writes through the standard `device_select`/`register_offset` handshake.

---
 rtl/multi_timer_io_device.sv | 180 ++++++++++++++++++
 tb/tb_multi_timer_io_device.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer_io_device.sv
// Up to three prescaled down-counting timers behind a 16-register I/O slot,
// with sticky write-1-to-clear expiry flags, a maskable interrupt and a cycle counter.
module multi_timer_io_device #(
    parameter int          NUM_TIMERS     = 3,
    parameter logic [15:0] PRESCALE_RESET = 16'd49999
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  device_select,
    input  logic [3:0]            register_offset,
    input  logic                  read_req,
    input  logic                  write_req,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata,
    output logic [NUM_TIMERS-1:0] timer_expired,
    output logic                  irq
);
    localparam logic [3:0]  OFF_STATUS   = 4'hC;
    localparam logic [3:0]  OFF_PRESCALE = 4'hD;
    localparam logic [3:0]  OFF_CYCLE    = 4'hE;
    localparam logic [3:0]  OFF_ID       = 4'hF;
    localparam logic [15:0] ID_VALUE     = {8'hA5, 6'd0, 2'(NUM_TIMERS)};

    logic                  wr_en;
    logic                  tick;
    logic [15:0]           presc_reg;
    logic [15:0]           presc_cnt_reg;
    logic [15:0]           cycle_reg;
    logic [NUM_TIMERS-1:0] status_reg;
    logic [NUM_TIMERS-1:0] expired_reg;
    logic [NUM_TIMERS-1:0] expire_now;
    logic [NUM_TIMERS-1:0] ie_vec;
    logic [NUM_TIMERS-1:0] clear_mask;

    // Four timer slots exist in the map; slots beyond NUM_TIMERS read as absent.
    logic [3:0]        present;
    logic [3:0][15:0]  count_q;
    logic [3:0][15:0]  reload_q;
    logic [3:0][2:0]   ctrl_q;

    logic [1:0] slot;
    logic [1:0] field;

    assign wr_en = write_req && device_select;
    assign tick  = (presc_cnt_reg == 16'd0);
    assign slot  = register_offset[3:2];
    assign field = register_offset[1:0];

    // Prescaler: a PRESCALE write restarts the period from the written value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg     <= PRESCALE_RESET;
            presc_cnt_reg <= PRESCALE_RESET;
        end else if (wr_en && (register_offset == OFF_PRESCALE)) begin
            presc_reg     <= wdata;
            presc_cnt_reg <= wdata;
        end else if (tick) begin
            presc_cnt_reg <= presc_reg;
        end else begin
            presc_cnt_reg <= presc_cnt_reg - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_reg <= '0;
        end else if (wr_en && (register_offset == OFF_CYCLE)) begin
            cycle_reg <= wdata;
        end else begin
            cycle_reg <= cycle_reg + 16'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_timer
            if (gi < NUM_TIMERS) begin : g_present
                localparam logic [3:0] BASE = 4'(4 * gi);

                logic [15:0] count_reg;
                logic [15:0] reload_reg;
                logic [2:0]  ctrl_reg;
                logic        count_wr;
                logic        reload_wr;
                logic        ctrl_wr;

                assign count_wr  = wr_en && (register_offset == BASE);
                assign reload_wr = wr_en && (register_offset == BASE + 4'd1);
                assign ctrl_wr   = wr_en && (register_offset == BASE + 4'd2);

                // A bus write to COUNT or CTRL pre-empts tick processing this cycle.
                assign expire_now[gi] = tick && ctrl_reg[0] && !count_wr && !ctrl_wr &&
                                        (count_reg <= 16'd1);

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        count_reg  <= '0;
                        reload_reg <= '0;
                        ctrl_reg   <= '0;
                    end else begin
                        if (reload_wr) begin
                            reload_reg <= wdata;
                        end
                        if (count_wr || ctrl_wr) begin
                            if (count_wr) begin
                                count_reg <= wdata;
                            end
                            if (ctrl_wr) begin
                                ctrl_reg <= wdata[2:0];
                            end
                        end else if (tick && ctrl_reg[0]) begin
                            if (count_reg <= 16'd1) begin
                                if (ctrl_reg[1]) begin
                                    count_reg <= reload_reg;
                                end else begin
                                    count_reg   <= '0;
                                    ctrl_reg[0] <= 1'b0;
                                end
                            end else begin
                                count_reg <= count_reg - 16'd1;
                            end
                        end
                    end
                end

                assign present[gi]  = 1'b1;
                assign count_q[gi]  = count_reg;
                assign reload_q[gi] = reload_reg;
                assign ctrl_q[gi]   = ctrl_reg;
                assign ie_vec[gi]   = ctrl_reg[2];
            end else begin : g_absent
                assign present[gi]  = 1'b0;
                assign count_q[gi]  = '0;
                assign reload_q[gi] = '0;
                assign ctrl_q[gi]   = '0;
            end
        end
    endgenerate

    assign clear_mask = (wr_en && (register_offset == OFF_STATUS)) ?
                        wdata[NUM_TIMERS-1:0] : '0;

    // Setting after clearing lets a same-cycle expiry beat the W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_reg  <= '0;
            expired_reg <= '0;
        end else begin
            status_reg  <= (status_reg & ~clear_mask) | expire_now;
            expired_reg <= expire_now;
        end
    end

    assign timer_expired = expired_reg;
    assign irq           = |(status_reg & ie_vec);

    always_comb begin
        rdata = 16'h0000;
        if (read_req && device_select) begin
            rdata = 16'hFFFF;
            case (register_offset)
                OFF_STATUS:   rdata = 16'(status_reg);
                OFF_PRESCALE: rdata = presc_reg;
                OFF_CYCLE:    rdata = cycle_reg;
                OFF_ID:       rdata = ID_VALUE;
                default: begin
                    if (present[slot]) begin
                        case (field)
                            2'd0:    rdata = count_q[slot];
                            2'd1:    rdata = reload_q[slot];
                            2'd2:    rdata = {13'd0, ctrl_q[slot]};
                            default: rdata = 16'hFFFF;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_timer_io_device.sv
// Self-checking bench for multi_timer_io_device: register table, randomized
// register traffic against a shadow model, and timed expiry scenarios.
`timescale 1ns/1ps
module tb_multi_timer_io_device;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        device_select = 1'b0;
    logic [3:0]  register_offset = 4'd0;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic [2:0]  timer_expired;
    logic        irq;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int last_edge = 0;
    int cyc_edge = 0;
    logic [15:0] mdl [16];

    typedef struct {
        bit          wr;
        bit          rd;
        bit          sel;
        logic [3:0]  off;
        logic [15:0] wd;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs [15];

    multi_timer_io_device dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .device_select   (device_select),
        .register_offset (register_offset),
        .read_req        (read_req),
        .write_req       (write_req),
        .wdata           (wdata),
        .rdata           (rdata),
        .timer_expired   (timer_expired),
        .irq             (irq)
    );

    always #10 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s got=%h", name, got);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else begin
            $display("ok   %s got=%0d", name, got);
        end
    endtask

    task automatic wr(input logic sel, input logic [3:0] off, input logic [15:0] d);
        @(negedge clk);
        device_select   = sel;
        write_req       = 1'b1;
        register_offset = off;
        wdata           = d;
        @(posedge clk);
        #1;
        write_req     = 1'b0;
        device_select = 1'b0;
        last_edge     = edge_n;
    endtask

    task automatic rd(input logic sel, input logic [3:0] off, output logic [15:0] got);
        @(negedge clk);
        device_select   = sel;
        read_req        = 1'b1;
        register_offset = off;
        #1;
        got           = rdata;
        read_req      = 1'b0;
        device_select = 1'b0;
    endtask

    task automatic wait_pulse(input int t, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (timer_expired[t]) begin
                at = edge_n;
                break;
            end
        end
    endtask

    // Expected register contents derived from the written values and elapsed edges.
    function automatic logic [15:0] model_read(input logic [3:0] off, input int n);
        if (off == 4'hF) return 16'hA503;
        if (off == 4'hE) return mdl[14] + 16'(n - cyc_edge);
        if (off == 4'hD) return mdl[13];
        if (off == 4'hC) return 16'h0000;
        if (off[1:0] == 2'd3) return 16'hFFFF;
        if (off[1:0] == 2'd2) return mdl[off] & 16'h0007;
        return mdl[off];
    endfunction

    function automatic vec_t mk(input bit w, input bit r, input bit s, input logic [3:0] o,
                                input logic [15:0] d, input logic [15:0] e, input string n);
        vec_t v;
        v.wr = w; v.rd = r; v.sel = s; v.off = o; v.wd = d; v.exp = e; v.name = n;
        return v;
    endfunction

    // One-shot expiry: the C-th prescaler tick strictly after the enabling write.
    task automatic oneshot(input int t, input int p, input int c);
        int e0, ec, m, xe, at;
        logic [3:0]  base;
        logic [15:0] got;
        base = 4'(4 * t);
        wr(1'b1, 4'hC, 16'h0007);
        wr(1'b1, 4'hD, 16'(p));
        e0 = last_edge;
        wr(1'b1, base, 16'(c));
        wr(1'b1, base + 4'd2, 16'h0005);
        ec = last_edge;
        m  = (ec - e0) / (p + 1) + 1;
        xe = e0 + (p + 1) * (m + c - 1);
        wait_pulse(t, 300, at);
        check_int($sformatf("os_t%0d_p%0d_c%0d_edge", t, p, c), at, xe);
        @(negedge clk);
        #1;
        check($sformatf("os_t%0d_width", t), 16'(timer_expired[t]), 16'h0000);
        rd(1'b1, 4'hC, got);
        check($sformatf("os_t%0d_status", t), got, 16'(1 << t));
        check($sformatf("os_t%0d_irq", t), 16'(irq), 16'h0001);
        rd(1'b1, base, got);
        check($sformatf("os_t%0d_count", t), got, 16'h0000);
        rd(1'b1, base + 4'd2, got);
        check($sformatf("os_t%0d_ctrl", t), got, 16'h0004);
        wr(1'b1, 4'hC, 16'(1 << t));
        check($sformatf("os_t%0d_irq_clr", t), 16'(irq), 16'h0000);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] d;
        logic [3:0]  off;
        int          op;
        int          ec;
        int          at;

        vecs[0]  = mk(0, 1, 1, 4'hF, 16'h0000, 16'hA503, "id");
        vecs[1]  = mk(0, 1, 1, 4'hD, 16'h0000, 16'hC34F, "presc_rst");
        vecs[2]  = mk(0, 1, 1, 4'h0, 16'h0000, 16'h0000, "count0_rst");
        vecs[3]  = mk(0, 1, 1, 4'h3, 16'h0000, 16'hFFFF, "rsvd3");
        vecs[4]  = mk(0, 1, 1, 4'hC, 16'h0000, 16'h0000, "status_rst");
        vecs[5]  = mk(0, 1, 1, 4'h2, 16'h0000, 16'h0000, "ctrl0_rst");
        vecs[6]  = mk(0, 1, 1, 4'hB, 16'h0000, 16'hFFFF, "rsvd11");
        vecs[7]  = mk(1, 1, 1, 4'h1, 16'h1234, 16'h1234, "reload0_wr");
        vecs[8]  = mk(1, 1, 1, 4'h2, 16'hFFFA, 16'h0002, "ctrl0_mask");
        vecs[9]  = mk(1, 1, 0, 4'h5, 16'h0055, 16'h0000, "nosel_wr");
        vecs[10] = mk(0, 1, 0, 4'hF, 16'h0000, 16'h0000, "nosel_rd");
        vecs[11] = mk(1, 1, 1, 4'hF, 16'h0000, 16'hA503, "id_ro");
        vecs[12] = mk(1, 1, 1, 4'h7, 16'h0001, 16'hFFFF, "rsvd7_wr");
        vecs[13] = mk(1, 1, 1, 4'h8, 16'hBEEF, 16'hBEEF, "count2_wr");
        vecs[14] = mk(1, 1, 1, 4'hC, 16'hFFFF, 16'h0000, "status_w1c0");

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("rst_irq", 16'(irq), 16'h0000);
        check("rst_expired", 16'(timer_expired), 16'h0000);
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) wr(vecs[i].sel, vecs[i].off, vecs[i].wd);
            if (vecs[i].rd) begin
                rd(vecs[i].wr ? 1'b1 : vecs[i].sel, vecs[i].off, got);
                check(vecs[i].name, got, vecs[i].exp);
            end
        end

        // Randomized register traffic with ticks held off by a large prescale.
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        wr(1'b1, 4'hD, 16'hFFFF);
        mdl[13] = 16'hFFFF;
        for (int i = 0; i < 12; i++) begin
            if ((i % 4) != 3) wr(1'b1, 4'(i), 16'h0000);
        end
        d = 16'($urandom);
        wr(1'b1, 4'hE, d);
        mdl[14] = d;
        cyc_edge = last_edge;
        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 3));
            off = 4'($urandom_range(0, 15));
            d   = 16'($urandom);
            if (op == 0) begin
                if (off == 4'hD) d = d | 16'h8000;
                wr(1'b1, off, d);
                if (off < 4'hC && off[1:0] != 2'd3) mdl[off] = d;
                else if (off == 4'hD) mdl[13] = d;
                else if (off == 4'hE) begin
                    mdl[14]  = d;
                    cyc_edge = last_edge;
                end
            end else if (op == 1) begin
                wr(1'b0, off, d);
            end else if (op == 2) begin
                rd(1'b1, off, got);
                check($sformatf("rnd%0d_off%h", i, off), got, model_read(off, edge_n));
            end else begin
                rd(1'b0, off, got);
                check($sformatf("rnd%0d_nosel_off%h", i, off), got, 16'h0000);
            end
        end

        wr(1'b1, 4'h2, 16'h0000);
        wr(1'b1, 4'h6, 16'h0000);
        wr(1'b1, 4'hA, 16'h0000);
        wr(1'b1, 4'hC, 16'h0007);

        oneshot(0, 3, 5);
        for (int i = 0; i < 4; i++) begin
            oneshot(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, 8)));
        end

        // Auto-reload every 4 ticks with IE clear.
        wr(1'b1, 4'hD, 16'h0000);
        wr(1'b1, 4'h5, 16'h0004);
        wr(1'b1, 4'h4, 16'h0004);
        wr(1'b1, 4'h6, 16'h0003);
        ec = last_edge;
        for (int k = 1; k <= 3; k++) begin
            wait_pulse(1, 20, at);
            check_int($sformatf("ar_edge%0d", k), at, ec + 4 * k);
            check($sformatf("ar_irq%0d", k), 16'(irq), 16'h0000);
            if (k == 1) begin
                rd(1'b1, 4'hC, got);
                check("ar_status", got, 16'h0002);
            end
        end
        wr(1'b1, 4'h6, 16'h0000);
        wr(1'b1, 4'hC, 16'h0007);

        // W1C landing on the same edge as the expiry.
        wr(1'b1, 4'h0, 16'h0003);
        wr(1'b1, 4'h2, 16'h0001);
        ec = last_edge;
        repeat (2) @(posedge clk);
        wr(1'b1, 4'hC, 16'h0001);
        check("col_pulse", 16'(timer_expired[0]), 16'h0001);
        rd(1'b1, 4'hC, got);
        check("col_status", got, 16'h0001);
        wr(1'b1, 4'hC, 16'h0001);
        rd(1'b1, 4'hC, got);
        check("col_status_clr", got, 16'h0000);

        // COUNT write on a tick edge wins over an imminent expiry.
        wr(1'b1, 4'h8, 16'h0001);
        wr(1'b1, 4'hA, 16'h0001);
        wr(1'b1, 4'h8, 16'h0009);
        check("prio_no_pulse", 16'(timer_expired[2]), 16'h0000);
        rd(1'b1, 4'h8, got);
        check("prio_count", got, 16'h0009);
        wr(1'b1, 4'hA, 16'h0000);

        // PRESCALE write on a tick edge: the tick is still processed.
        wr(1'b1, 4'h0, 16'h0001);
        wr(1'b1, 4'h2, 16'h0005);
        wr(1'b1, 4'hD, 16'h0005);
        check("presc_tick_pulse", 16'(timer_expired[0]), 16'h0001);
        check("presc_tick_irq", 16'(irq), 16'h0001);

        wr(1'b1, 4'hE, 16'hFFFE);
        rd(1'b1, 4'hE, got);
        check("cyc_fffe", got, 16'hFFFE);
        rd(1'b1, 4'hE, got);
        check("cyc_ffff", got, 16'hFFFF);
        rd(1'b1, 4'hE, got);
        check("cyc_wrap", got, 16'h0000);

        // Asynchronous reset between clock edges.
        wr(1'b1, 4'h5, 16'd77);
        check("pre_rst_irq", 16'(irq), 16'h0001);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_irq", 16'(irq), 16'h0000);
        check("arst_expired", 16'(timer_expired), 16'h0000);
        device_select = 1'b1;
        read_req      = 1'b1;
        register_offset = 4'h5;
        #1 check("arst_reload1", rdata, 16'h0000);
        register_offset = 4'hD;
        #1 check("arst_presc", rdata, 16'hC34F);
        register_offset = 4'hC;
        #1 check("arst_status", rdata, 16'h0000);
        register_offset = 4'hE;
        #1 check("arst_cycle", rdata, 16'h0000);
        register_offset = 4'h2;
        #1 check("arst_ctrl0", rdata, 16'h0000);
        read_req      = 1'b0;
        device_select = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(1'b1, 4'hD, got);
        check("post_rst_presc", got, 16'hC34F);
        rd(1'b1, 4'hF, got);
        check("post_rst_id", got, 16'hA503);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
